serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 25 ++
 rtl/full_adder_cell.sv | 19 +
 rtl/serial_adder.sv | 112 +++++++++++
 tb/tb_serial_adder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encodings and helpers for serial_adder
//
// Purpose: common definitions for the bit-serial adder/subtractor.
//   state_t : FSM encodings ST_IDLE / ST_RUN / ST_DONE
//   clog2() : bit counter width for a given operand width (minimum 1)
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter width for values 0..n-1; never narrower than one bit so that
    // WIDTH=1 still gets a real register.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - combinational one-bit full adder
//
// Purpose: the single full-adder cell reused every cycle by serial_adder.
// Ports:
//   a, b, cin : operand bits and carry in
//   s         : sum bit
//   cout      : carry out
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder/subtractor with start/done
//
// Purpose: adds or subtracts two WIDTH-bit operands LSB-first, one bit per
// clock, through a single full_adder_cell.
// Ports:
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   start    : request, sampled only while idle
//   sub      : 0 = a+b, 1 = a-b (latched with the operands)
//   a, b     : operands, latched on an accepted start
//   busy     : high while running and during the done cycle
//   done     : one-cycle pulse when sum/cout/ovf are valid
//   sum      : result modulo 2^WIDTH
//   cout     : carry out (for subtract, 1 = no borrow)
//   ovf      : two's-complement overflow
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int             CW   = clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_c;

    full_adder_cell u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                        a_sh  <= a;
                        // Subtraction is a + ~b + 1: invert B here and use
                        // the initial carry as the +1.
                        b_sh  <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                        ovf   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // New bit enters at the MSB so the LSB-first stream
                    // ends up in place after WIDTH shifts.
                    sum   <= (sum >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= fa_c;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // carry still holds the carry into the MSB here.
                        cout  <= fa_c;
                        ovf   <= carry ^ fa_c;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (WIDTH 1 and 8)
module tb_serial_adder;

    logic       clk;
    logic       rst;

    logic       start1, sub1;
    logic [0:0] a1, b1, sum1;
    logic       busy1, done1, cout1, ovf1;

    logic       start8, sub8;
    logic [7:0] a8, b8, sum8;
    logic       busy8, done8, cout8, ovf8;

    int n_checks;
    int n_fail;

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic void model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                  input logic sv, output logic [31:0] es,
                                  output logic ec, output logic eo);
        longint m, ua, ub, sa, sb, u, s;
        m  = longint'(1) << w;
        ua = longint'(av) & (m - 1);
        ub = longint'(bv) & (m - 1);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (sv) begin
            u  = ua - ub;
            s  = sa - sb;
            ec = (ua >= ub);
        end else begin
            u  = ua + ub;
            s  = sa + sb;
            ec = (u >= m);
        end
        es = 32'(u & (m - 1));
        eo = (s >= m / 2) || (s < -(m / 2));
    endfunction

    task automatic set_in(input int w, input logic st, input logic [31:0] av,
                          input logic [31:0] bv, input logic sv);
        if (w == 1) begin
            start1 = st; a1 = av[0:0]; b1 = bv[0:0]; sub1 = sv;
        end else begin
            start8 = st; a8 = av[7:0]; b8 = bv[7:0]; sub8 = sv;
        end
    endtask

    function automatic logic rd_done(input int w);
        return (w == 1) ? done1 : done8;
    endfunction
    function automatic logic rd_busy(input int w);
        return (w == 1) ? busy1 : busy8;
    endfunction
    function automatic logic [31:0] rd_sum(input int w);
        return (w == 1) ? {31'd0, sum1} : {24'd0, sum8};
    endfunction
    function automatic logic rd_cout(input int w);
        return (w == 1) ? cout1 : cout8;
    endfunction
    function automatic logic rd_ovf(input int w);
        return (w == 1) ? ovf1 : ovf8;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One operation; operands are scrambled every cycle after acceptance.
    // poke re-raises start during RUN and during the DONE cycle.
    task automatic do_op(input int w, input logic [31:0] av, input logic [31:0] bv,
                         input logic sv, input logic poke);
        logic [31:0] es;
        logic        ec, eo;
        int          n;
        int          extra;
        model(w, av, bv, sv, es, ec, eo);
        @(negedge clk);
        set_in(w, 1'b1, av, bv, sv);
        @(posedge clk); #1;
        set_in(w, 1'b0, $urandom, $urandom, rbit());
        check_eq("busy_after_start", 32'(rd_busy(w)), 32'd1);
        n = 1;
        while (!rd_done(w) && n < 40) begin
            set_in(w, poke && (n == 3), $urandom, $urandom, rbit());
            @(posedge clk); #1;
            n++;
        end
        check_eq("latency", n, w + 1);
        check_eq("sum", rd_sum(w), es);
        check_eq("cout", 32'(rd_cout(w)), 32'(ec));
        check_eq("ovf", 32'(rd_ovf(w)), 32'(eo));
        check_eq("busy_in_done", 32'(rd_busy(w)), 32'd1);
        set_in(w, poke, $urandom, $urandom, rbit());
        @(posedge clk); #1;
        set_in(w, 1'b0, $urandom, $urandom, rbit());
        check_eq("done_one_cycle", 32'(rd_done(w)), 32'd0);
        check_eq("busy_idle", 32'(rd_busy(w)), 32'd0);
        check_eq("sum_hold", rd_sum(w), es);
        if (poke) begin
            extra = 0;
            repeat (4) begin
                @(posedge clk); #1;
                if (rd_done(w) || rd_busy(w)) extra++;
            end
            check_eq("poke_ignored", extra, 0);
            check_eq("poke_sum_hold", rd_sum(w), es);
        end
    endtask

    initial begin
        logic [31:0] es1, es2;
        logic        ec1, eo1, ec2, eo2;
        logic [31:0] x1, y1, x2, y2;
        logic        s1, s2;
        int          n, pulses;

        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        set_in(1, 1'b0, 0, 0, 1'b0);
        set_in(8, 1'b0, 0, 0, 1'b0);
        #12;
        check_eq("rst_busy8", 32'(busy8), 32'd0);
        check_eq("rst_done8", 32'(done8), 32'd0);
        check_eq("rst_sum8", 32'(sum8), 32'd0);
        check_eq("rst_cout8", 32'(cout8), 32'd0);
        check_eq("rst_ovf8", 32'(ovf8), 32'd0);
        check_eq("rst_busy1", 32'(busy1), 32'd0);
        check_eq("rst_sum1", 32'(sum1), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // WIDTH=1 exhaustive over (a, b, sub)
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            do_op(1, {31'd0, v[2]}, {31'd0, v[1]}, v[0], 1'b0);
        end

        // WIDTH=8 directed cases
        do_op(8, 3, 5, 1'b0, 1'b0);
        do_op(8, 200, 100, 1'b0, 1'b0);
        do_op(8, 100, 50, 1'b0, 1'b0);
        do_op(8, 5, 7, 1'b1, 1'b0);
        do_op(8, 7, 5, 1'b1, 1'b0);
        do_op(8, 32'h80, 1, 1'b1, 1'b0);
        do_op(8, 32'hFF, 32'hFF, 1'b0, 1'b0);
        do_op(8, 0, 0, 1'b1, 1'b0);

        // start re-raised during RUN and DONE
        do_op(8, 32'h3C, 32'h47, 1'b0, 1'b1);
        do_op(8, 32'h10, 32'h20, 1'b1, 1'b1);

        // randomized
        for (int i = 0; i < 24; i++) begin
            do_op(8, $urandom, $urandom, rbit(), 1'b0);
        end

        // back-to-back with start held high
        x1 = $urandom; y1 = $urandom; s1 = rbit();
        x2 = $urandom; y2 = $urandom; s2 = rbit();
        model(8, x1, y1, s1, es1, ec1, eo1);
        model(8, x2, y2, s2, es2, ec2, eo2);
        @(negedge clk);
        set_in(8, 1'b1, x1, y1, s1);
        @(posedge clk); #1;
        set_in(8, 1'b1, x2, y2, s2);
        n = 1;
        while (!done8 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("b2b_lat1", n, 9);
        check_eq("b2b_sum1", 32'(sum8), es1 & 32'hFF);
        check_eq("b2b_cout1", 32'(cout8), 32'(ec1));
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done8 && n < 40);
        check_eq("b2b_interval", n, 10);
        check_eq("b2b_sum2", 32'(sum8), es2 & 32'hFF);
        check_eq("b2b_ovf2", 32'(ovf8), 32'(eo2));
        set_in(8, 1'b0, 0, 0, 1'b0);
        repeat (2) @(posedge clk);

        // reset in the middle of an operation
        @(negedge clk);
        set_in(8, 1'b1, 32'hFF, 0, 1'b0);
        @(posedge clk); #1;
        set_in(8, 1'b0, 32'hFF, 0, 1'b0);
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_eq("midrst_busy", 32'(busy8), 32'd0);
        check_eq("midrst_done", 32'(done8), 32'd0);
        check_eq("midrst_sum", 32'(sum8), 32'd0);
        check_eq("midrst_cout", 32'(cout8), 32'd0);
        check_eq("midrst_ovf", 32'(ovf8), 32'd0);
        pulses = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done8) pulses++;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done8 || busy8) pulses++;
        end
        check_eq("midrst_no_done", pulses, 0);
        do_op(8, 1, 1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
